sound_write_scheduler: RTL and testbench

SOUND_WRITE_SCHEDULER -- requirements
Module: sound_write_scheduler

---
 rtl/sound_write_scheduler.sv | 133 +++++++++++++
 tb/tb_sound_write_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_write_scheduler.sv
// Host-to-generator write scheduler: master-count prescaler plus a write queue drained in the safe window.
// Optional feature: define SYNC_WRITE_EN to gate pops with the safe window (otherwise always open).
module sound_write_scheduler #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter int unsigned CLK_DIV         = 1
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       run_in,
    input  logic                       flush_in,
    input  logic                       host_valid_in,
    input  logic [5:0]                 host_addr_in,
    input  logic [15:0]                host_data_in,
    output logic                       host_ready_out,
    output logic [9:0]                 master_count_out,
    output logic [5:0]                 addr_out,
    output logic [15:0]                data_out,
    output logic                       data_valid_out,
    output logic                       sample_tick_out,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level_out
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned LW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [7:0]    PRESC_MAX  = 8'(CLK_DIV - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [7:0]                 r_presc;
    logic [9:0]                 r_count;
    logic                       r_tick;

    logic [5:0]                 r_mem_addr [DEPTH];
    logic [15:0]                r_mem_data [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [LW-1:0]              r_level;

    logic [5:0]                 r_addr;
    logic [15:0]                r_data;
    logic                       r_valid;

    logic                       w_full;
    logic                       w_ready;
    logic                       w_window;
    logic                       w_push;
    logic                       w_pop;

`ifdef SYNC_WRITE_EN
    // Closed across the wrap region 0x3FF..0x00F while the counter is running.
    assign w_window = !run_in || ((r_count[9:4] != 6'd0) && (r_count != 10'h3FF));
`else
    assign w_window = 1'b1;
`endif

    assign w_full  = (r_level == LEVEL_FULL);
    assign w_ready = reset_in && !w_full;
    // Flush wins over both a simultaneous push and any pop.
    assign w_push  = host_valid_in && w_ready && !flush_in;
    assign w_pop   = !flush_in && (r_level != '0) && w_window;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_presc <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (run_in) begin
                if (r_presc == PRESC_MAX) begin
                    r_presc <= '0;
                    r_count <= r_count + 10'd1;
                    r_tick  <= (r_count == 10'h3FF);
                end else begin
                    r_presc <= r_presc + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= host_addr_in;
            r_mem_data[r_wr_ptr] <= host_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_pop;
            if (w_pop) begin
                r_addr <= r_mem_addr[r_rd_ptr];
                r_data <= r_mem_data[r_rd_ptr];
            end
        end
    end

    assign host_ready_out   = w_ready;
    assign master_count_out = r_count;
    assign addr_out         = r_addr;
    assign data_out         = r_data;
    assign data_valid_out   = r_valid;
    assign sample_tick_out  = r_tick;
    assign fifo_level_out   = r_level;

endmodule

// File: tb/tb_sound_write_scheduler.sv
// Bench for sound_write_scheduler: reference model of counter and queue, scoreboard of accepted writes,
// a table of cycle vectors plus hand-written sequences for wrap, window, back-pressure and reset.
module tb_sound_write_scheduler;

    localparam int CLK_DIV = 1;
    localparam int DEPTH   = 4;

    logic        clk_in;
    logic        reset_in;
    logic        run_in;
    logic        flush_in;
    logic        host_valid_in;
    logic [5:0]  host_addr_in;
    logic [15:0] host_data_in;
    logic        host_ready_out;
    logic [9:0]  master_count_out;
    logic [5:0]  addr_out;
    logic [15:0] data_out;
    logic        data_valid_out;
    logic        sample_tick_out;
    logic [2:0]  fifo_level_out;

    sound_write_scheduler #(
        .FIFO_DEPTH_LOG2(2),
        .CLK_DIV        (CLK_DIV)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .run_in          (run_in),
        .flush_in        (flush_in),
        .host_valid_in   (host_valid_in),
        .host_addr_in    (host_addr_in),
        .host_data_in    (host_data_in),
        .host_ready_out  (host_ready_out),
        .master_count_out(master_count_out),
        .addr_out        (addr_out),
        .data_out        (data_out),
        .data_valid_out  (data_valid_out),
        .sample_tick_out (sample_tick_out),
        .fifo_level_out  (fifo_level_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [5:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [5:0]  a;
        logic [15:0] d;
        logic [2:0]  exp_level;
        logic        exp_dv;
        logic [5:0]  exp_a;
        logic [15:0] exp_d;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          tick_seen = 0;
    logic [9:0]  m_count;
    int          m_presc;
    logic [5:0]  m_addr;
    logic [15:0] m_data;
    wr_t         sb[$];
    logic [9:0]  strobe_cnt[$];
    bit          acc;
    vec_t        tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit window(input logic [9:0] c, input logic run);
`ifdef SYNC_WRITE_EN
        return !run || ((c[9:4] != 6'd0) && (c != 10'h3FF));
`else
        return (run | !run);
`endif
    endfunction

    // One clock: predict from pre-edge state, then compare after the edge.
    task automatic step(output bit accepted);
        int  sz;
        bit  exp_pop;
        bit  exp_push;
        bit  exp_tick;
        wr_t e;
        sz       = sb.size();
        exp_pop  = !flush_in && (sz > 0) && window(m_count, run_in);
        exp_push = host_valid_in && (sz < DEPTH) && !flush_in;
        exp_tick = 1'b0;
        if (run_in) begin
            if (m_presc == CLK_DIV - 1) begin
                m_presc  = 0;
                exp_tick = (m_count == 10'h3FF);
                m_count  = m_count + 10'd1;
            end else begin
                m_presc++;
            end
        end
        @(posedge clk_in);
        #1;
        chk("count", 32'(master_count_out), 32'(m_count));
        chk("sample_tick", 32'(sample_tick_out), 32'(exp_tick));
        if (sample_tick_out) tick_seen++;
        chk("strobe", 32'(data_valid_out), 32'(exp_pop));
        if (data_valid_out) begin
            strobe_cnt.push_back(master_count_out);
            chk("strobe_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e      = sb.pop_front();
                m_addr = e.a;
                m_data = e.d;
            end
        end
        chk("addr_out", 32'(addr_out), 32'(m_addr));
        chk("data_out", 32'(data_out), 32'(m_data));
        if (flush_in) begin
            sb.delete();
        end else if (exp_push) begin
            e.a = host_addr_in;
            e.d = host_data_in;
            sb.push_back(e);
        end
        chk("level", 32'(fifo_level_out), 32'(sb.size()));
        chk("ready", 32'(host_ready_out), 32'(sb.size() < DEPTH));
        accepted = exp_push;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"}, 32'(master_count_out), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level_out), 32'd0);
        chk({tag, "_addr"},  32'(addr_out), 32'd0);
        chk({tag, "_data"},  32'(data_out), 32'd0);
        chk({tag, "_dv"},    32'(data_valid_out), 32'd0);
        chk({tag, "_tick"},  32'(sample_tick_out), 32'd0);
        chk({tag, "_ready"}, 32'(host_ready_out), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset_in = 1'b0;
        #1;
        chk_reset_outputs(tag);
        host_valid_in = 1'b0;
        flush_in      = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_reset_outputs({tag, "_held"});
        reset_in = 1'b1;
        m_count  = '0;
        m_presc  = 0;
        m_addr   = '0;
        m_data   = '0;
        sb.delete();
        strobe_cnt.delete();
        #1;
        chk({tag, "_first_count"}, 32'(master_count_out), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_cnt033;
        logic [9:0] exp_cnt035;
`ifdef SYNC_WRITE_EN
        exp_cnt033 = 10'h011;
        exp_cnt035 = 10'h011;
`else
        exp_cnt033 = 10'h007;
        exp_cnt035 = 10'h000;
`endif
        tbl[0] = '{1'b1, 1'b0, 6'h01, 16'h1234, 3'd1, 1'b0, 6'h00, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 6'h01, 16'h1234};
        tbl[2] = '{1'b1, 1'b0, 6'h02, 16'hAAAA, 3'd1, 1'b0, 6'h01, 16'h1234};
        tbl[3] = '{1'b1, 1'b0, 6'h03, 16'hBBBB, 3'd1, 1'b1, 6'h02, 16'hAAAA};
        tbl[4] = '{1'b1, 1'b1, 6'h04, 16'hCCCC, 3'd0, 1'b0, 6'h02, 16'hAAAA};
        tbl[5] = '{1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b0, 6'h02, 16'hAAAA};
        tbl[6] = '{1'b1, 1'b0, 6'h05, 16'h5555, 3'd1, 1'b0, 6'h02, 16'hAAAA};
        tbl[7] = '{1'b1, 1'b0, 6'h06, 16'h6666, 3'd1, 1'b1, 6'h05, 16'h5555};
        tbl[8] = '{1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 6'h06, 16'h6666};
        tbl[9] = '{1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b0, 6'h06, 16'h6666};

        reset_in      = 1'b1;
        run_in        = 1'b0;
        flush_in      = 1'b0;
        host_valid_in = 1'b0;
        host_addr_in  = '0;
        host_data_in  = '0;
        #2;
        do_reset("rst");

        // Table vectors with the counter stopped (window open in every build).
        run_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            host_valid_in = tbl[i].valid;
            flush_in      = tbl[i].flush;
            host_addr_in  = tbl[i].a;
            host_data_in  = tbl[i].d;
            step(acc);
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level_out), 32'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_dv", i),    32'(data_valid_out), 32'(tbl[i].exp_dv));
            chk($sformatf("tbl%0d_addr", i),  32'(addr_out), 32'(tbl[i].exp_a));
            chk($sformatf("tbl%0d_data", i),  32'(data_out), 32'(tbl[i].exp_d));
        end
        host_valid_in = 1'b0;
        flush_in      = 1'b0;

        // Full count cycle and wrap pulse.
        do_reset("rst032");
        run_in    = 1'b1;
        tick_seen = 0;
        repeat (1023) step(acc);
        chk("wrap_count_3ff", 32'(master_count_out), 32'h3FF);
        step(acc);
        chk("wrap_count_0", 32'(master_count_out), 32'h000);
        chk("wrap_tick", 32'(sample_tick_out), 32'd1);
        step(acc);
        chk("wrap_tick_once", 32'(tick_seen), 32'd1);

        // Single write pushed at count 0x005.
        do_reset("rst033");
        run_in = 1'b1;
        repeat (5) step(acc);
        host_valid_in = 1'b1;
        host_addr_in  = 6'h01;
        host_data_in  = 16'h1234;
        step(acc);
        host_valid_in = 1'b0;
        for (int i = 0; i < 40 && strobe_cnt.size() == 0; i++) step(acc);
        chk("req033_strobe_seen", 32'(strobe_cnt.size() > 0), 32'd1);
        if (strobe_cnt.size() > 0)
            chk("req033_strobe_count", 32'(strobe_cnt[0]), 32'(exp_cnt033));
        chk("req033_addr", 32'(addr_out), 32'h01);
        chk("req033_data", 32'(data_out), 32'h1234);

        // Entries straddling the wrap region.
        do_reset("rst035");
        run_in = 1'b1;
        repeat (1021) step(acc);
        host_valid_in = 1'b1;
        host_addr_in  = 6'h2A;
        host_data_in  = 16'h0F0F;
        step(acc);
        host_addr_in  = 6'h2B;
        host_data_in  = 16'hF0F0;
        step(acc);
        host_valid_in = 1'b0;
        for (int i = 0; i < 40 && strobe_cnt.size() < 2; i++) step(acc);
        chk("req035_two_strobes", 32'(strobe_cnt.size() >= 2), 32'd1);
        if (strobe_cnt.size() >= 2) begin
            chk("req035_first_at", 32'(strobe_cnt[0]), 32'h3FF);
            chk("req035_second_at", 32'(strobe_cnt[1]), 32'(exp_cnt035));
        end

        // Back-to-back burst of five writes from reset.
        do_reset("rst034");
        run_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            host_valid_in = 1'b1;
            host_addr_in  = 6'(6'h30 + k);
            host_data_in  = 16'(16'hA000 + k);
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) step(acc);
            chk($sformatf("req034_accept%0d", k), 32'(acc), 32'd1);
        end
        host_valid_in = 1'b0;
        repeat (20) step(acc);
        chk("req034_strobes", 32'(strobe_cnt.size()), 32'd5);
        chk("req034_drained", 32'(fifo_level_out), 32'd0);
        chk("req034_last_addr", 32'(addr_out), 32'h34);
        chk("req034_last_data", 32'(data_out), 32'hA004);

        // Asynchronous reset mid-count with writes in flight.
        do_reset("rst037a");
        run_in = 1'b1;
        repeat (341) step(acc);
        chk("req037_at_155", 32'(master_count_out), 32'h155);
        host_valid_in = 1'b1;
        host_addr_in  = 6'h11;
        host_data_in  = 16'h2222;
        step(acc);
        host_addr_in  = 6'h12;
        host_data_in  = 16'h3333;
        step(acc);
        host_valid_in = 1'b0;
        #3;
        do_reset("req037");
        repeat (8) step(acc);
        chk("req037_no_strobes", 32'(strobe_cnt.size()), 32'd0);
        chk("req037_count_after", 32'(master_count_out), 32'h008);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
